mem_port_arbiter: RTL

- Arbitrates and sequences a single shared memory port between two requesters: CPU control path (port "cpu") and an external loader/IO master (port "ext").
- Sits between the control/datapath memory signals and the memory array.
- Round-robin fairness; drives the one-cycle memory strobe, waits out read latency, returns data with a done pulse.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sequencing one shared memory port (cpu / ext).
// Optional macro ARB_LOCK_EN adds cpu_lock so the CPU can hold the port across accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              Rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner,
    output logic              busy,
    output logic [7:0]        ext_wait_cnt
`ifdef ARB_LOCK_EN
    ,
    input  logic              cpu_lock
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              stateNext;

    logic                ownerQ;
    logic                lastOwner;
    logic                weQ;
    logic [ADDR_W-1:0]   addrQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [3:0]          latCnt;

    logic                extBlocked;
    logic                extEligible;
    logic                grantAny;
    logic                pickExt;

`ifdef ARB_LOCK_EN
    logic                lockHeld;
`endif

    // Arbitration decision; only acted upon while IDLE
    always_comb begin
`ifdef ARB_LOCK_EN
        extBlocked = lockHeld && cpu_lock;
`else
        extBlocked = 1'b0;
`endif
        extEligible = ext_req && !extBlocked;
        grantAny    = cpu_req || extEligible;
        pickExt     = extEligible && (!cpu_req || !lastOwner);
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: begin
                if (grantAny) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr  = addrQ;
                mem_wdata = wdataQ;
                mem_we    = weQ;
                mem_re    = !weQ;
                stateNext = weQ ? DONE : WAIT;
            end
            WAIT: begin
                if (latCnt == 4'd1) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
        endcase

        busy     = (state != IDLE);
        owner    = busy && ownerQ;
        cpu_gnt  = busy && !ownerQ;
        ext_gnt  = busy && ownerQ;
        cpu_done = (state == DONE) && !ownerQ;
        ext_done = (state == DONE) && ownerQ;
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            ownerQ    <= 1'b0;
            lastOwner <= 1'b1;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            latCnt    <= '0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
`ifdef ARB_LOCK_EN
            lockHeld  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grantAny) begin
                        ownerQ <= pickExt;
                        weQ    <= pickExt ? ext_we    : cpu_we;
                        addrQ  <= pickExt ? ext_addr  : cpu_addr;
                        wdataQ <= pickExt ? ext_wdata : cpu_wdata;
                    end
`ifdef ARB_LOCK_EN
                    if (!cpu_lock) begin
                        lockHeld <= 1'b0;
                    end
`endif
                end
                ISSUE: begin
                    latCnt <= 4'(MEM_LAT);
                end
                WAIT: begin
                    latCnt <= latCnt - 4'd1;
                    if (latCnt == 4'd1) begin
                        if (ownerQ) begin
                            ext_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    lastOwner <= ownerQ;
`ifdef ARB_LOCK_EN
                    if (!ownerQ) begin
                        lockHeld <= cpu_lock;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            ext_wait_cnt <= '0;
        end else if (ext_req && !ext_gnt && (ext_wait_cnt != 8'hFF)) begin
            ext_wait_cnt <= ext_wait_cnt + 8'd1;
        end
    end

endmodule
